// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the return-stack operation encoding.
package cpu_pkg;

  localparam int unsigned ADDR_WIDTH   = 8;
  localparam int unsigned RSTACK_DEPTH = 8;

  // Encoded as {push, pop} so the control decoder can drive the stack strobes directly.
  typedef enum logic [1:0] {
    NOP     = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } rstack_op_t;

endpackage

// File: rtl/return_stack_mem.sv
// Register file for the return stack: one synchronous write port, one asynchronous read port.
module return_stack_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_stack.sv
// Hardware LIFO of return addresses feeding the program counter's load path.
module return_stack
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_WIDTH,
  parameter int unsigned DEPTH = RSTACK_DEPTH,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear_err,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CW-1:0]    count_d, count_q;
  logic             ovf_d, ovf_q;
  logic             udf_d, udf_q;
  logic             ovf_set, udf_set;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] rdata;
  rstack_op_t       op;

  assign op      = rstack_op_t'({push, pop});
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // Wraps to all-ones when empty; the read is masked below in that case.
  assign top_idx = AW'(count_q - CW'(1));

  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    we      = 1'b0;
    waddr   = top_idx;
    unique case (op)
      NOP: ;
      PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = AW'(count_q);
          count_d = count_q + CW'(1);
        end
      end
      POP: begin
        if (empty) begin
          udf_set = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      REPLACE: begin
        we = 1'b1;
        // Nothing to replace when empty: the push still lands, the pop is the error.
        if (empty) begin
          udf_set = 1'b1;
          waddr   = '0;
          count_d = CW'(1);
        end
      end
    endcase

    ovf_d = (ovf_q & ~clear_err) | ovf_set;
    udf_d = (udf_q & ~clear_err) | udf_set;

    if (rst) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    ovf_q   <= ovf_d;
    udf_q   <= udf_d;
  end

  return_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign top       = empty ? '0 : rdata;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: driver queues expected state, monitor checks after each edge.
module tb_return_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = '0;
  logic       pop = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] top;
  logic [3:0] count;
  logic       empty, full, overflow, underflow;

  always #5 clk = ~clk;

  return_stack dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear_err (clear_err),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    string      name;
    logic [3:0] count;
    logic [7:0] top;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failed = 0;

  // Monitor: the DUT presents a new state every cycle; check it away from the active edge.
  initial begin
    exp_t e;
    logic e_empty, e_full;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        e_empty = (e.count == 4'd0);
        e_full  = (e.count == 4'd8);
        tests++;
        if (count !== e.count || top !== e.top || empty !== e_empty || full !== e_full ||
            overflow !== e.ovf || underflow !== e.udf) begin
          failed++;
          $display("FAIL %s: got count=%0d top=%h empty=%b full=%b ovf=%b udf=%b, want count=%0d top=%h empty=%b full=%b ovf=%b udf=%b",
                   e.name, count, top, empty, full, overflow, underflow,
                   e.count, e.top, e_empty, e_full, e.ovf, e.udf);
        end
      end
    end
  end

  task automatic step(input string name, input logic r, input logic pu, input logic po,
                      input logic clr, input logic [7:0] d, input logic [3:0] ecount,
                      input logic [7:0] etop, input logic eovf, input logic eudf);
    exp_t e;
    rst = r; push = pu; pop = po; clear_err = clr; push_data = d;
    @(posedge clk);
    e.name = name; e.count = ecount; e.top = etop; e.ovf = eovf; e.udf = eudf;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    #1;
    // 1: reset
    step("rst0", 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    step("rst1", 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);

    // 2: push three, pop three
    step("push12", 0, 1, 0, 0, 8'h12, 1, 8'h12, 0, 0);
    step("push34", 0, 1, 0, 0, 8'h34, 2, 8'h34, 0, 0);
    step("push56", 0, 1, 0, 0, 8'h56, 3, 8'h56, 0, 0);
    step("pop1",   0, 0, 1, 0, 8'h00, 2, 8'h34, 0, 0);
    step("pop2",   0, 0, 1, 0, 8'h00, 1, 8'h12, 0, 0);
    step("pop3",   0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);

    // 3: fill, overflow, pop
    for (int i = 0; i < 8; i++)
      step($sformatf("fill%0d", i), 0, 1, 0, 0, 8'(8'h10 + i), 4'(i + 1), 8'(8'h10 + i), 0, 0);
    step("push_full",     0, 1, 0, 0, 8'h99, 8, 8'h17, 1, 0);
    step("ovf_clr_race",  0, 1, 0, 1, 8'h98, 8, 8'h17, 1, 0);
    step("pop_after_ovf", 0, 0, 1, 0, 8'h00, 7, 8'h16, 1, 0);
    step("clr_ovf",       0, 0, 0, 1, 8'h00, 7, 8'h16, 0, 0);
    step("rst_a",         1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);

    // 4: underflow and clear
    step("pop_empty",     0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
    step("clr_udf",       0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    step("udf_clr_race",  0, 0, 1, 1, 8'h00, 0, 8'h00, 0, 1);
    step("clr_udf2",      0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);

    // 5: simultaneous push and pop
    step("p20", 0, 1, 0, 0, 8'h20, 1, 8'h20, 0, 0);
    step("p21", 0, 1, 0, 0, 8'h21, 2, 8'h21, 0, 0);
    step("p22", 0, 1, 0, 0, 8'h22, 3, 8'h22, 0, 0);
    step("repl44",     0, 1, 1, 0, 8'h44, 3, 8'h44, 0, 0);
    step("pop_repl",   0, 0, 1, 0, 8'h00, 2, 8'h21, 0, 0);
    for (int i = 0; i < 6; i++)
      step($sformatf("fill5_%0d", i), 0, 1, 0, 0, 8'(8'h30 + i), 4'(i + 3), 8'(8'h30 + i), 0, 0);
    step("repl_full",  0, 1, 1, 0, 8'h55, 8, 8'h55, 0, 0);
    step("pop_rfull",  0, 0, 1, 0, 8'h00, 7, 8'h34, 0, 0);
    step("rst_b",      1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    step("repl_empty", 0, 1, 1, 0, 8'h77, 1, 8'h77, 0, 1);
    step("pop_last",   0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
    step("clr_c",      0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);

    // 6: reset dominates push with count=5 and overflow set
    for (int i = 0; i < 8; i++)
      step($sformatf("fill6_%0d", i), 0, 1, 0, 0, 8'(8'h01 + i), 4'(i + 1), 8'(8'h01 + i), 0, 0);
    step("ovf6",   0, 1, 0, 0, 8'hEE, 8, 8'h08, 1, 0);
    step("pop6a",  0, 0, 1, 0, 8'h00, 7, 8'h07, 1, 0);
    step("pop6b",  0, 0, 1, 0, 8'h00, 6, 8'h06, 1, 0);
    step("pop6c",  0, 0, 1, 0, 8'h00, 5, 8'h05, 1, 0);
    step("rst_push", 1, 1, 0, 0, 8'hAA, 0, 8'h00, 0, 0);
    step("idle_after_rst", 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    step("push_after_rst", 0, 1, 0, 0, 8'hBB, 1, 8'hBB, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/return_stack.md
# return_stack

Hardware LIFO of return addresses. It forms the other end of the program counter's store/increment interface. On a call, control pushes the return address derived from the program counter output. On a return, control pops, and the stack's `top` value drives the program counter's `data_in` while control asserts the counter's `store`. The block sits beside the program counter in the CPU datapath and is driven only by the control unit.

## Interface
Parameters:
- `WIDTH`, default 8: address width; must match the program counter width.
- `DEPTH`, default 8: number of entries; power of two, at least 2.
- `CW`, derived as `$clog2(DEPTH+1)`: width of `count`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `push`, in, 1: write `push_data` as the new top of stack.
- `push_data`, in, `WIDTH`: return address to store.
- `pop`, in, 1: remove the top entry.
- `clear_err`, in, 1: clear the sticky error flags.
- `top`, out, `WIDTH`: current top entry; 0 while empty.
- `count`, out, `CW`: number of valid entries, 0..`DEPTH`.
- `empty`, out, 1: `count == 0`.
- `full`, out, 1: `count == DEPTH`.
- `overflow`, out, 1: sticky; a push was dropped because the stack was full.
- `underflow`, out, 1: sticky; a pop was attempted while the stack was empty.

## Operation
- Storage is `DEPTH` entries plus a `count` register. The top entry lives at index `count-1`.
- `top` is a combinational read of entry `count-1`, forced to 0 when `count == 0`. No other output is combinational.
- Push only, not full: write `push_data` at index `count`, then `count+1`.
- Push only, full: contents and `count` unchanged; set `overflow`.
- Pop only, not empty: `count-1`. The vacated entry is not cleared.
- Pop only, empty: no change; set `underflow`.
- Push and pop together, not empty: replace the entry at `count-1` with `push_data`; `count` unchanged. This is legal when full and does not set `overflow`.
- Push and pop together, empty: the push executes (`count` becomes 1) and `underflow` is set.
- `clear_err` clears both flags. If an error condition occurs in the same cycle, setting wins.
- Reset: `count` = 0 and both flags = 0, which gives `empty` = 1, `full` = 0 and `top` = 0. Storage contents are not reset.

## Timing
- All state updates happen on the rising edge of `clk`.
- A push or pop sampled at edge N is visible on `count`, `top`, `empty`, `full` and the flags immediately after edge N.
- Return sequence, single cycle: `top` is valid before the pop. Control asserts `pop` and the program counter's `store` in the same cycle, and the counter captures `top` at the same edge the stack decrements.
- Call sequence: `push_data` must be valid in the cycle `push` is high. No handshake and no back-pressure.
- Back-to-back pushes and pops at one operation per cycle are fully supported.
- `rst` dominates. If `push`/`pop` are asserted in the reset cycle, `count` is 0 after the edge.
- Reset mid-operation discards the stack logically: `top` reads 0 until the next push.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_WIDTH` (8) and `RSTACK_DEPTH` (8) constants, used as the defaults for `WIDTH` and `DEPTH`.
  - Stack operation encoding enum `rstack_op_t`: `NOP`, `PUSH`, `POP`, `REPLACE`, used by the control unit's decoder.
- Sub-module `return_stack_mem`: `DEPTH` x `WIDTH` register file with one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`).
- The top level holds `count`, the flags, op decode, and the address/mux logic.

## Test plan
1. Assert `rst` for 2 cycles -> `count` = 0, `empty` = 1, `full` = 0, `top` = 0x00, `overflow` = `underflow` = 0.
2. Push 0x12, 0x34, 0x56 on consecutive cycles, then pop three times -> `top` reads 0x56, then 0x34, then 0x12 before each pop; `count` goes 3, 2, 1, 0; `empty` = 1 at the end with `top` = 0x00.
3. Push 0x10..0x17 (`DEPTH` = 8) -> `full` = 1, `count` = 8, `top` = 0x17. Then push 0x99 -> `overflow` = 1, `top` = 0x17, `count` = 8. Then pop -> `top` = 0x16.
4. Pop while empty -> `underflow` = 1, `count` = 0. `clear_err` alone -> `underflow` = 0. `clear_err` together with a pop while empty -> `underflow` = 1.
5. Push and pop together:
   - `count` = 3, `top` = 0x22, `push_data` = 0x44 -> `count` = 3, `top` = 0x44.
   - Repeat while full -> `count` = 8, no `overflow`.
   - Push and pop together while empty with 0x77 -> `count` = 1, `top` = 0x77, `underflow` = 1.
6. With `count` = 5 and `overflow` = 1, assert `rst` together with `push` -> next cycle `count` = 0, `empty` = 1, `top` = 0x00, `overflow` = 0.
